// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one single-port memory between the instruction-fetch
// (read-only) and data-access (read/write) ports, with one transaction in flight at a time.
module mem_arbiter #(
   parameter int READ_LATENCY = 1,
   parameter int DATA_W       = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_req,
   input  logic [31:0]       i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_rw,
   input  logic [31:0]       d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic [31:0]       mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rw,
   output logic              mem_en,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   localparam logic [2:0] LAT = 3'(READ_LATENCY);

   state_t     state, state_nxt;
   logic [2:0] cnt, cnt_nxt;
   logic       last_d;
   logic       owner_d;
   logic       capture;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      i_gnt     = 1'b0;
      d_gnt     = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            // On a tie the port that was not served last wins.
            if (!reset && (i_req || d_req)) begin
               if (d_req && (!i_req || !last_d)) d_gnt = 1'b1;
               else                               i_gnt = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (mem_rw) begin
               cnt_nxt   = LAT;
               state_nxt = WAIT;
            end else begin
               state_nxt = IDLE;
            end
         end
         WAIT: begin
            cnt_nxt = cnt - 3'd1;
            if (cnt == 3'd1) begin
               capture   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 3'd0;
         last_d    <= 1'b1;
         owner_d   <= 1'b0;
         mem_en    <= 1'b0;
         mem_rw    <= 1'b1;
         mem_addr  <= '0;
         mem_wdata <= '0;
         i_rvalid  <= 1'b0;
         d_rvalid  <= 1'b0;
         i_rdata   <= '0;
         d_rdata   <= '0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         mem_en   <= i_gnt | d_gnt;
         i_rvalid <= capture & ~owner_d;
         d_rvalid <= capture & owner_d;
         // Memory-side fields change only on a grant so they hold between transactions.
         if (d_gnt) begin
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_rw    <= d_rw;
            owner_d   <= 1'b1;
            last_d    <= 1'b1;
         end else if (i_gnt) begin
            mem_addr  <= i_addr;
            mem_rw    <= 1'b1;
            owner_d   <= 1'b0;
            last_d    <= 1'b0;
         end
         if (capture && !owner_d) i_rdata <= mem_rdata;
         if (capture && owner_d)  d_rdata <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: four instances (READ_LATENCY 1..4), each with its own memory
// emulation, directed scenarios, random traffic and a timestamp-based reference model.
module tb_mem_arbiter;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;
   int lanes_done = 0;
   int cyc = 0;

   logic [3:0]  reset, i_req, i_gnt, i_rvalid, d_req, d_rw, d_gnt, d_rvalid, mem_rw, mem_en;
   logic [31:0] i_addr [4];
   logic [31:0] i_rdata [4];
   logic [31:0] d_addr [4];
   logic [31:0] d_wdata [4];
   logic [31:0] d_rdata [4];
   logic [31:0] mem_addr [4];
   logic [31:0] mem_wdata [4];
   logic [31:0] mem_rdata [4];

   function automatic logic [31:0] init_word(int i);
      return (i == 1) ? 32'h20020005 : (32'hC0DE0000 ^ 32'(i * 32'h00010101));
   endfunction

   function automatic void chk(int k, string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL lane%0d %s: got %h expected %h (t=%0t)", k, name, act, exp, $time);
      end
   endfunction

   function automatic void fail_now(int k, string name);
      checks++;
      failures++;
      $display("FAIL lane%0d %s: bound expired (t=%0t)", k, name, $time);
   endfunction

   for (genvar g = 0; g < 4; g++) begin : lane
      localparam int L = g + 1;
      logic [31:0] mem_a [256];
      logic [31:0] pipe [4];

      mem_arbiter #(.READ_LATENCY(L), .DATA_W(32)) dut (
         .clock     (clock),
         .reset     (reset[g]),
         .i_req     (i_req[g]),
         .i_addr    (i_addr[g]),
         .i_gnt     (i_gnt[g]),
         .i_rvalid  (i_rvalid[g]),
         .i_rdata   (i_rdata[g]),
         .d_req     (d_req[g]),
         .d_rw      (d_rw[g]),
         .d_addr    (d_addr[g]),
         .d_wdata   (d_wdata[g]),
         .d_gnt     (d_gnt[g]),
         .d_rvalid  (d_rvalid[g]),
         .d_rdata   (d_rdata[g]),
         .mem_addr  (mem_addr[g]),
         .mem_wdata (mem_wdata[g]),
         .mem_rw    (mem_rw[g]),
         .mem_en    (mem_en[g]),
         .mem_rdata (mem_rdata[g])
      );

      initial for (int i = 0; i < 256; i++) mem_a[i] = init_word(i);

      // Memory emulation: read data appears L cycles after the enable cycle.
      always @(posedge clock) begin
         if (mem_en[g]) begin
            pipe[0] <= mem_a[mem_addr[g][9:2]];
            if (!mem_rw[g]) mem_a[mem_addr[g][9:2]] <= mem_wdata[g];
         end
         for (int s = 1; s < 4; s++) pipe[s] <= pipe[s-1];
      end
      assign mem_rdata[g] = pipe[L-1];

      initial run_lane(g);
   end

   // Reference model: each transaction is a set of timestamps derived at grant time.
   int          free_at [4];
   int          issue_at [4];
   int          rv_at [4];
   bit          mvalid [4];
   bit          rv_own [4];
   bit          last_d [4];
   bit          m_rw [4];
   logic [31:0] m_addr [4];
   logic [31:0] m_wdata [4];
   logic [31:0] e_ird [4];
   logic [31:0] e_drd [4];
   logic [31:0] pend [4];
   logic [31:0] mmem [4][256];

   initial begin
      for (int k = 0; k < 4; k++)
         for (int i = 0; i < 256; i++) mmem[k][i] = init_word(i);
   end

   always @(negedge clock) begin : model
      int lat;
      bit idle, gi, gd;
      logic [31:0] a;
      for (int k = 0; k < 4; k++) begin
         lat = k + 1;
         gi  = 1'b0;
         gd  = 1'b0;
         if (mvalid[k]) begin
            if (cyc == rv_at[k]) begin
               if (rv_own[k]) e_drd[k] = pend[k];
               else           e_ird[k] = pend[k];
            end
            idle = !reset[k] && (cyc >= free_at[k]);
            gi   = idle && i_req[k] && (!d_req[k] || last_d[k]);
            gd   = idle && d_req[k] && (!i_req[k] || !last_d[k]);
            chk(k, "m_i_gnt", i_gnt[k], gi);
            chk(k, "m_d_gnt", d_gnt[k], gd);
            chk(k, "m_mem_en", mem_en[k], cyc == issue_at[k]);
            chk(k, "m_mem_addr", mem_addr[k], m_addr[k]);
            chk(k, "m_mem_wdata", mem_wdata[k], m_wdata[k]);
            chk(k, "m_mem_rw", mem_rw[k], m_rw[k]);
            chk(k, "m_i_rvalid", i_rvalid[k], (cyc == rv_at[k]) && !rv_own[k]);
            chk(k, "m_d_rvalid", d_rvalid[k], (cyc == rv_at[k]) && rv_own[k]);
            chk(k, "m_i_rdata", i_rdata[k], e_ird[k]);
            chk(k, "m_d_rdata", d_rdata[k], e_drd[k]);
         end
         if (reset[k]) begin
            mvalid[k]   = 1'b1;
            last_d[k]   = 1'b1;
            free_at[k]  = cyc + 1;
            issue_at[k] = -1;
            rv_at[k]    = -1;
            m_addr[k]   = '0;
            m_wdata[k]  = '0;
            m_rw[k]     = 1'b1;
            e_ird[k]    = '0;
            e_drd[k]    = '0;
         end else if (gi || gd) begin
            a           = gd ? d_addr[k] : i_addr[k];
            last_d[k]   = gd;
            m_addr[k]   = a;
            m_rw[k]     = gd ? d_rw[k] : 1'b1;
            if (gd) m_wdata[k] = d_wdata[k];
            issue_at[k] = cyc + 1;
            if (m_rw[k]) begin
               pend[k]    = mmem[k][a[9:2]];
               rv_at[k]   = cyc + 2 + lat;
               rv_own[k]  = gd;
               free_at[k] = cyc + 2 + lat;
            end else begin
               mmem[k][a[9:2]] = d_wdata[k];
               free_at[k]      = cyc + 2;
            end
         end
      end
      cyc++;
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Raise a request and hold it until granted; returns just after the cycle following gnt.
   task automatic issue(int k, bit is_d, bit rw, logic [31:0] addr, logic [31:0] wdata,
                        output int waited);
      bit g;
      if (is_d) begin
         d_req[k] = 1'b1; d_rw[k] = rw; d_addr[k] = addr; d_wdata[k] = wdata;
      end else begin
         i_req[k] = 1'b1; i_addr[k] = addr;
      end
      waited = -1;
      for (int n = 0; n < 64; n++) begin
         @(negedge clock);
         g = is_d ? d_gnt[k] : i_gnt[k];
         step();
         if (g) begin
            waited = n;
            break;
         end
      end
      if (is_d) d_req[k] = 1'b0;
      else      i_req[k] = 1'b0;
      if (waited < 0) fail_now(k, "gnt_timeout");
   endtask

   // Called in the cycle after the grant: checks the issue cycle and the rvalid timing.
   task automatic expect_read(int k, bit is_d, logic [31:0] addr, logic [31:0] data, string tag);
      for (int j = 0; j <= k + 2; j++) begin
         @(negedge clock);
         if (j == 0) begin
            chk(k, {tag, "_mem_en"}, mem_en[k], 1);
            chk(k, {tag, "_mem_addr"}, mem_addr[k], addr);
            chk(k, {tag, "_mem_rw"}, mem_rw[k], 1);
         end
         chk(k, {tag, "_rvalid"}, is_d ? d_rvalid[k] : i_rvalid[k], j == k + 2);
         chk(k, {tag, "_other_rvalid"}, is_d ? i_rvalid[k] : d_rvalid[k], 0);
         if (j == k + 2) chk(k, {tag, "_rdata"}, is_d ? d_rdata[k] : i_rdata[k], data);
         step();
      end
   endtask

   task automatic run_lane(int k);
      int w, n, ni, rep, nv, ng;
      bit seq [8];
      int vcyc [3];
      logic [31:0] vdat [3];
      bit g;

      reset[k] = 1'b1; i_req[k] = 1'b1; i_addr[k] = '0;
      d_req[k] = 1'b1; d_rw[k] = 1'b1; d_addr[k] = 32'h10; d_wdata[k] = '0;
      step();
      for (int c = 0; c < 2; c++) begin
         @(negedge clock);
         chk(k, "rst_i_gnt", i_gnt[k], 0);
         chk(k, "rst_d_gnt", d_gnt[k], 0);
         chk(k, "rst_mem_en", mem_en[k], 0);
         chk(k, "rst_mem_rw", mem_rw[k], 1);
         chk(k, "rst_mem_addr", mem_addr[k], 0);
         step();
      end
      reset[k] = 1'b0;
      @(negedge clock);
      chk(k, "rel_i_gnt", i_gnt[k], 1);
      chk(k, "rel_d_gnt", d_gnt[k], 0);
      step();
      i_req[k] = 1'b0; d_req[k] = 1'b0;
      repeat (k + 4) step();

      issue(k, 0, 1, 32'h4, '0, w);
      chk(k, "rd_wait", w, 0);
      expect_read(k, 0, 32'h4, 32'h20020005, "rd");

      issue(k, 1, 0, 32'h8, 32'h12341234, w);
      @(negedge clock);
      chk(k, "wr_mem_en", mem_en[k], 1);
      chk(k, "wr_mem_rw", mem_rw[k], 0);
      chk(k, "wr_mem_addr", mem_addr[k], 32'h8);
      chk(k, "wr_mem_wdata", mem_wdata[k], 32'h12341234);
      chk(k, "wr_d_rvalid", d_rvalid[k], 0);
      step();
      issue(k, 1, 1, 32'h8, '0, w);
      chk(k, "wb_wait", w, 0);
      expect_read(k, 1, 32'h8, 32'h12341234, "wb");

      i_req[k] = 1'b1; i_addr[k] = 32'h10;
      d_req[k] = 1'b1; d_rw[k] = 1'b1; d_addr[k] = 32'h14;
      n = 0;
      for (int c = 0; c < 200 && n < 8; c++) begin
         @(negedge clock);
         if (i_gnt[k])      begin seq[n] = 1'b0; n++; end
         else if (d_gnt[k]) begin seq[n] = 1'b1; n++; end
         step();
      end
      i_req[k] = 1'b0; d_req[k] = 1'b0;
      chk(k, "cont_grants", n, 8);
      ni = 0; rep = 0;
      for (int j = 0; j < n; j++) begin
         if (!seq[j]) ni++;
         if (j > 0 && seq[j] == seq[j-1]) rep++;
      end
      chk(k, "cont_first_is_i", seq[0], 0);
      chk(k, "cont_repeats", rep, 0);
      chk(k, "cont_i_count", ni, 4);
      repeat (k + 4) step();

      issue(k, 0, 1, 32'h0, '0, w);
      chk(k, "rw_i_wait", w, 0);
      d_req[k] = 1'b1; d_rw[k] = 1'b1; d_addr[k] = 32'hC;
      step();
      reset[k] = 1'b1;
      step();
      reset[k] = 1'b0;
      @(negedge clock);
      chk(k, "rw_d_gnt", d_gnt[k], 1);
      chk(k, "rw_i_gnt", i_gnt[k], 0);
      chk(k, "rw_i_rvalid", i_rvalid[k], 0);
      step();
      d_req[k] = 1'b0;
      expect_read(k, 1, 32'hC, init_word(3), "rw_d");

      d_req[k] = 1'b1; d_rw[k] = 1'b1; d_addr[k] = 32'h0;
      nv = 0; ng = 0;
      for (int c = 0; c < 80 && nv < 3; c++) begin
         @(negedge clock);
         g = d_gnt[k];
         if (d_rvalid[k]) begin
            vcyc[nv] = c;
            vdat[nv] = d_rdata[k];
            nv++;
         end
         step();
         if (g) begin
            ng++;
            if (ng < 3) d_addr[k] = 32'(ng * 4);
            else        d_req[k] = 1'b0;
         end
      end
      d_req[k] = 1'b0;
      chk(k, "sw_count", nv, 3);
      chk(k, "sw_space01", vcyc[1] - vcyc[0], k + 3);
      chk(k, "sw_space12", vcyc[2] - vcyc[1], k + 3);
      chk(k, "sw_data0", vdat[0], init_word(0));
      chk(k, "sw_data1", vdat[1], 32'h20020005);
      chk(k, "sw_data2", vdat[2], 32'h12341234);
      repeat (2) step();

      for (int c = 0; c < 300; c++) begin
         @(negedge clock);
         g = i_gnt[k];
         w = d_gnt[k];
         step();
         if (g || !i_req[k]) begin
            i_req[k]  = ($urandom_range(0, 2) == 0);
            i_addr[k] = 32'($urandom_range(0, 1023));
         end
         if (w != 0 || !d_req[k]) begin
            d_req[k]   = ($urandom_range(0, 2) == 0);
            d_rw[k]    = 1'($urandom_range(0, 1));
            d_addr[k]  = 32'($urandom_range(0, 1023));
            d_wdata[k] = $urandom;
         end
         reset[k] = ($urandom_range(0, 63) == 0);
      end
      reset[k] = 1'b0; i_req[k] = 1'b0; d_req[k] = 1'b0;
      repeat (12) step();
      lanes_done++;
   endtask

   initial begin
      for (int t = 0; t < 6000 && lanes_done < 4; t++) @(posedge clock);
      if (lanes_done < 4) fail_now(-1, "lane_timeout");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter that shares the single-port 32-bit `mem` block between the instruction-fetch path (read-only) and the data-access path (read/write) of the MIPS core. Each requester uses a req/gnt handshake. The arbiter drives `mem` through its registered issue stage, counts out the memory read latency, and returns read data with a one-cycle valid pulse. The block is non-pipelined: one memory transaction is in flight at a time.

## Interface
- `READ_LATENCY`, 1: cycles from the `mem_en` cycle to valid `mem_rdata`; legal range 1..4.
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_req`  in  1  instruction read request; held high with `i_addr` stable until `i_gnt`.
- `i_addr`  in  32  instruction byte address.
- `i_gnt`  out  1  request accepted this cycle (combinational, IDLE only).
- `i_rvalid`  out  1  one-cycle pulse; `i_rdata` is valid.
- `i_rdata`  out  32  registered read data; holds until the next capture.
- `d_req`  in  1  data request; held high with `d_rw`/`d_addr`/`d_wdata` stable until `d_gnt`.
- `d_rw`  in  1  1 = read, 0 = write (same encoding as `mem`).
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  32  write data.
- `d_gnt`  out  1  request accepted this cycle.
- `d_rvalid`  out  1  one-cycle pulse for a data read; never pulses for writes.
- `d_rdata`  out  32  registered read data.
- `mem_addr`  out  32  to `mem` `w_addr_32`.
- `mem_wdata`  out  32  to `mem` `w_data_in_32`.
- `mem_rw`  out  1  to `mem` `rw`.
- `mem_en`  out  1  to `mem` `en`; high exactly one cycle per transaction.
- `mem_rdata`  in  32  from `mem` `w_data_out_32`.

## Operation
- States:
  - IDLE: arbitrate.
  - ISSUE: `mem_en`=1.
  - WAIT: count down read latency.
- IDLE:
  - If any request is present, assert exactly one gnt.
  - On that edge, register `mem_addr`, `mem_wdata`, `mem_rw` (`i` side: `mem_rw`=1 and `mem_wdata` unchanged), record the owner, and go to ISSUE.
- ISSUE:
  - Write: return to IDLE.
  - Read: load `cnt`=READ_LATENCY and go to WAIT.
- WAIT:
  - Decrement `cnt`.
  - When `cnt`==1, capture `mem_rdata` into the owner's `*_rdata` and go to IDLE.
  - The owner's `*_rvalid` is high in the following cycle.
- Round-robin:
  - A `last` register records the most recent grantee.
  - With both requesting, grant the port that is not `last`.
  - With a single requester, grant it regardless of `last`.
  - Reset sets `last`=D, so `i` wins the first tie.
- No gnt outside IDLE; requests wait without loss.
- Addresses pass unchanged; no alignment check (`mem` handles word indexing).
- Reset values:
  - All gnt/rvalid: 0.
  - `mem_en`: 0.
  - `mem_rw`: 1.
  - `mem_addr`, `mem_wdata`, `i_rdata`, `d_rdata`: 0.
  - State IDLE, `cnt` 0.
- Reset mid-transaction: aborts immediately to IDLE.
  - No rvalid pulse.
  - In-flight read data is discarded.
  - A write already issued to `mem` is not undone.
- `mem_addr`/`mem_wdata`/`mem_rw` hold their last values while `mem_en`=0.

## Timing
- Gnt in cycle N: ISSUE (`mem_en`=1) in N+1.
- Read: WAIT occupies N+2 .. N+1+READ_LATENCY, capture at the end of N+1+READ_LATENCY, rvalid in N+2+READ_LATENCY.
- Read latency gnt→rvalid = READ_LATENCY+2 (3 at default).
- The rvalid cycle is IDLE, so a new gnt may coincide with rvalid.
- Write: IDLE again in N+2, so the next gnt is possible in N+2.
- Throughput:
  - One write per 2 cycles.
  - One read per READ_LATENCY+2 cycles.
- Requester may drop req in the cycle after its gnt; req still high then is a new request.
- gnt is combinational from req in IDLE; rvalid/rdata/mem_* are registered.

## Test plan
- Reset: hold `reset` 2 cycles with `i_req`=`d_req`=1 → both gnt=0, `mem_en`=0, `mem_rw`=1, `mem_addr`=0; after release, `i_gnt`=1 in the first cycle.
- Single instruction read, READ_LATENCY=1: preload `mem[0x4]`=0x20020005, `i_req`=1 with `i_addr`=0x4 → `i_gnt` in cycle N, `mem_en`=1 with `mem_addr`=0x4 and `mem_rw`=1 in N+1, `i_rvalid`=1 with `i_rdata`=0x20020005 in N+3, `d_rvalid` stays 0.
- Data write then read-back:
  - Write `d_addr`=0x8, `d_wdata`=0x12341234 → `mem_en`=1, `mem_rw`=0 in N+1, no `d_rvalid`.
  - Read 0x8 granted at N+2 → `d_rvalid` with 0x12341234 at N+5.
- Contention: both ports request continuously for 8 grants → grants alternate I,D,I,D,…; no port granted twice in a row; each port gets 4 grants.
- Reset mid-WAIT, READ_LATENCY=3: assert `reset` in the first WAIT cycle of an `i` read → no `i_rvalid` ever for that read; IDLE next cycle; a pending `d_req` is granted in the first cycle after reset is released.
- Latency sweep READ_LATENCY=1..4: back-to-back reads from 0x0,0x4,0x8 on the `d` port → `d_rvalid` spacing equals READ_LATENCY+2 cycles and data matches memory contents.
